booth_mac_accum: RTL
====================

// Module: booth_mac_accum
// PURPOSE
//  Downstream consumer of the 8x8 radix-4 Booth multiplier. Tracks operand pairs launched
//  into the multiplier, aligns valid/last with its fixed latency, and accumulates the signed
//  16-bit products into a dot-product sum. Returns one sum per vector over a valid/ready output.
// PARAMETERS
//  ACC_W     24  accumulator/result width (>=16); products sign-extended to ACC_W
//  MULT_LAT  2   multiplier latency in clocks, operand launch edge -> product registered
//  CNT_W     8   term-counter width; saturates at all-ones
// PORTS
//  clk        in   1         system clock, rising edge
//  rst        in   1         asynchronous, active-low reset
//  op_valid   in   1         operand pair presented to the multiplier this cycle
//  op_last    in   1         qualifies op_valid: final term of the vector
//  in_ready   out  1         block accepts operands; launch is op_valid && in_ready
//  prod       in   16        multiplier product, two's-complement signed; carry output unused
//  acc_out    out  ACC_W     completed dot-product sum, signed
//  term_cnt   out  CNT_W     number of terms in acc_out
//  out_valid  out  1         acc_out/term_cnt valid
//  out_ready  in   1         consumer accepts result on out_valid && out_ready
//  sat_flag   out  1         sticky per-vector saturation indicator (0 when macro absent)
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; valid pipe, acc, count cleared;
//    in_ready=0 during reset, 1 in the first cycle after release; out_valid=0, acc_out=0,
//    term_cnt=0, sat_flag=0. Multiplier rst shares this net; in-flight products are discarded.
//  - Valid pipe: MULT_LAT-deep shift of {launch, op_last}; stage MULT_LAT-1 marks prod valid.
//  - States: IDLE -> ACCUM on the first valid product (acc <= sext(prod), cnt <= 1).
//    ACCUM: each valid product, acc <= acc + sext(prod), cnt <= cnt+1 (sat at 2^CNT_W-1).
//    Valid product tagged last -> HOLD, with the final term included in the same cycle.
//    A single-term vector goes IDLE -> HOLD directly.
//    HOLD: out_valid=1; acc_out/term_cnt held stable until out_ready; then -> IDLE and
//    out_valid=0 next cycle. No combinational path from out_ready to out_valid.
//  - in_ready = 0 from the cycle after the op_last launch until HOLD is left, so no product
//    of a new vector is in flight while the result waits. in_ready returns 1 the cycle after
//    handshake; the next vector's first product arrives MULT_LAT cycles after its launch.
//  - Gaps (op_valid=0) inside a vector allowed; bubbles do not change acc or cnt.
//  - op_last without op_valid is ignored. Arithmetic: signed, sext(prod) to ACC_W; wraps
//    modulo 2^ACC_W unless macro enabled.
// CONFIGURATION
//  `MAC_SAT_EN defined: add saturates to +(2^(ACC_W-1)-1) / -2^(ACC_W-1); sat_flag set on
//   any clipped add in the vector, cleared on output handshake or reset.
//  Undefined: two's-complement wrap; sat_flag tied 0; no saturation logic synthesised.
// STRUCTURE
//  - Shared package mac_pkg: state encoding (IDLE, ACCUM, HOLD), PROD_W=16, ACC_W/CNT_W
//    defaults, saturation-limit constants.
//  - Sub-module mac_valid_pipe (params DEPTH=MULT_LAT): async-reset shift register for {valid,last}.
//  - Top: FSM, accumulator adder/saturator, counter, output hold registers.
// TESTING
//  1. 4-term vector (3,4),(-5,6),(127,127),(-128,-128), out_ready=1 -> acc_out=32495,
//     term_cnt=4, out_valid exactly 1 cycle, MULT_LAT cycles after last launch.
//  2. Single term (-128,127) with op_last -> acc_out=-16256, term_cnt=1; IDLE->HOLD->IDLE.
//  3. Backpressure: finish vector, hold out_ready=0 5 cycles -> acc_out stable, out_valid=1,
//     in_ready=0 throughout; op_valid pulses ignored; release -> in_ready=1 next cycle.
//  4. ACC_W=16, terms (-128,-128)x2: with MAC_SAT_EN -> 32767, sat_flag=1; without -> -32768,
//     sat_flag=0.
//  5. Bubbles: 3 terms (1,1) with 2 idle cycles between each -> acc_out=3, term_cnt=3.
//  6. Reset mid-vector after 2 launches -> all outputs 0 immediately; next vector (2,3) last
//     -> acc_out=6, term_cnt=1, no residue from the aborted vector.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the Booth-product dot-product accumulator.
// Saturation build option: define MAC_SAT_EN.
package mac_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } mac_state_e;

  localparam int unsigned PROD_W    = 16;
  localparam int unsigned ACC_W_DEF = 24;
  localparam int unsigned CNT_W_DEF = 8;

  localparam logic [ACC_W_DEF-1:0] ACC_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/mac_valid_pipe.sv
// Shift register that tracks {valid, last} alongside the multiplier's fixed latency.
module mac_valid_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid,
  input  logic i_last,
  output logic o_valid,
  output logic o_last
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_last  <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_last[0]  <= i_valid & i_last;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_last[i]  <= r_last[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_last  = r_last[DEPTH-1];

endmodule

// File: rtl/booth_mac_accum.sv
// Accumulates signed Booth products into a per-vector dot product with a valid/ready result.
// Optional saturating add when MAC_SAT_EN is defined; otherwise wraps and sat flag is 0.
module booth_mac_accum
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter int unsigned MULT_LAT = 2,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_op_valid,
  input  logic              i_op_last,
  output logic              o_in_ready,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_acc_out,
  output logic [CNT_W-1:0]  o_term_cnt,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_sat_flag
);

  mac_state_e       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic             r_block;

  logic             w_launch;
  logic             w_prod_vld;
  logic             w_prod_last;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_handshake;

  // Held low while a finished vector waits, so no new product can be in flight.
  assign o_in_ready  = i_rst_n & ~r_block;
  assign w_launch    = i_op_valid & o_in_ready;
  assign w_handshake = (r_state == StHold) & i_out_ready;

  mac_valid_pipe #(
    .DEPTH(MULT_LAT)
  ) u_valid_pipe (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(w_launch),
    .i_last (i_op_last),
    .o_valid(w_prod_vld),
    .o_last (w_prod_last)
  );

  assign w_prod_ext = ACC_W'($signed(i_prod));
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

`ifdef MAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] w_sum_wide;
  logic           w_clip;
  logic           r_sat;

  assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_prod_ext[ACC_W-1], w_prod_ext};
  assign w_clip     = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];
  assign w_sum      = w_clip ? (w_sum_wide[ACC_W] ? ACC_MIN : ACC_MAX)
                             : w_sum_wide[ACC_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sat <= 1'b0;
    end else if (w_handshake) begin
      r_sat <= 1'b0;
    end else if ((r_state == StAccum) && w_prod_vld && w_clip) begin
      r_sat <= 1'b1;
    end
  end

  assign o_sat_flag = r_sat;
`else
  assign w_sum      = r_acc + w_prod_ext;
  assign o_sat_flag = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_block     <= 1'b0;
    end else begin
      if (w_launch && i_op_last) begin
        r_block <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (w_prod_vld) begin
            r_acc <= w_prod_ext;
            r_cnt <= CNT_W'(1);
            if (w_prod_last) begin
              r_state     <= StHold;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= StAccum;
            end
          end
        end
        StAccum: begin
          if (w_prod_vld) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_inc;
            if (w_prod_last) begin
              r_state     <= StHold;
              r_out_valid <= 1'b1;
            end
          end
        end
        StHold: begin
          if (i_out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_block     <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_acc_out   = r_acc;
  assign o_term_cnt  = r_cnt;
  assign o_out_valid = r_out_valid;

endmodule
